wb_arbiter: RTL and testbench
=============================

# wb_arbiter

Write-back arbiter that closes the result path of the pipeline: it accepts completed results from the EX, MUL, DIV and FPU units over per-source valid/ready handshakes and drives the single register-file write port (`rd_wena_to_WB`/`rd_addr_to_WB`/`rd_data_to_WB`) that the decode stage's register file consumes. It grants one source per cycle with fixed priority plus a starvation override. Optionally, it keeps a pending-write scoreboard so decode can stall on long-latency destinations.

## Interface
- `N_SRC`, default 4: number of result sources; index 0 = highest base priority.
- `STARVE_LIM`, default 3: number of consecutive denied cycles after which a source is promoted; must be ≥ 1.
- `clk` input 1: clock, rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `valid_in` input N_SRC: per-source result valid.
- `ready_out` output N_SRC: per-source grant; a transfer occurs on `valid_in[i] && ready_out[i]`.
- `rd_addr_in` input 6*N_SRC: destination per source, slice i = bits [6i+5:6i]; bit 5 set = FP register.
- `rd_data_in` input 32*N_SRC: result data per source, slice i = bits [32i+31:32i].
- `rd_wena_to_WB` output 1: registered write enable to the register file.
- `rd_addr_to_WB` output 6: registered write address.
- `rd_data_to_WB` output 32: registered write data.
- `sb_set` input 1: decode issued a long-latency instruction that writes `sb_addr`.
- `sb_addr` input 6: destination to mark pending.
- `busy` output 64: pending-write mask, bit n = register n awaits write-back.

## Operation
- **Per-source wait counter** `wait_cnt[i]`, saturating at `STARVE_LIM`:
  - increments when `valid_in[i] && !ready_out[i]`;
  - clears on a transfer or when `valid_in[i]` is low.
- **Starvation:** source i is starved when `wait_cnt[i] == STARVE_LIM`.
- **Grant selection** (combinational, one-hot or zero):
  - if any valid source is starved, grant the lowest-index starved valid source;
  - otherwise, grant the lowest-index valid source;
  - no valid sources means `ready_out` = 0.
- **Source rule:** once `valid_in[i]` is asserted, the source holds it, with address and data stable, until the transfer. The arbiter does not depend on a source dropping `valid_in` early.
- **Output register:** loads on every cycle.
  - `rd_wena_to_WB` <= transfer occurred AND granted address ≠ 6'd0.
  - Address and data are loaded from the granted slice.
  - With no transfer, `rd_wena_to_WB` <= 0 and address/data <= 0.
- **x0 writes:** address 0 is accepted (handshake completes) but suppressed. Address 32 (f0) is a normal write.
- **Scoreboard update per edge:**
  - set `busy[sb_addr]` when `sb_set` is high;
  - clear `busy[granted addr]` on a transfer.
  - When set and clear target the same address in one cycle, set wins: the new issue supersedes.
  - `busy[0]` is always 0.
- **Flush:** this block has no flush input. Completed results always commit, and units are responsible for squashing their own flushed results.

## Timing
- **Reset:** `ready_out` = 0 (all sources invalid after reset), `rd_wena_to_WB` = 0, `rd_addr_to_WB` = 0, `rd_data_to_WB` = 0, `busy` = 0, all `wait_cnt` = 0. Reset asserted mid-operation discards the pending grant and the output register.
- **Grant:** `ready_out` is combinational from `valid_in` and `wait_cnt`, so acceptance takes zero cycles.
- **Write latency:** the write appears on the `_to_WB` outputs in the cycle after the transfer, for exactly one cycle.
- **Throughput:** one write per cycle, so back-to-back transfers from the same or different sources are allowed.
- **Starvation bound:** a valid source waits at most `STARVE_LIM` cycles plus the number of lower-index starved sources.
- **Busy timing:** a `busy` bit rises one cycle after `sb_set` and falls in the same cycle that `rd_wena_to_WB` is presented.

## Configuration
- Macro `WB_SCOREBOARD_EN`.
- **Defined:** the scoreboard is built as described above.
- **Undefined:** `busy` is tied to 64'h0, and `sb_set`/`sb_addr` are ignored with no flops inferred. Arbitration and write-back behaviour are identical in both builds.

## Structure
- Shared package CPU_pkg gains the source indices `WB_SRC_EX`=0, `WB_SRC_MUL`=1, `WB_SRC_DIV`=2, `WB_SRC_FPU`=3, and the constant `WB_STARVE_LIM_DEF`=3.
- Sub-module `wb_scoreboard`:
  - holds the 64-bit busy register with set/clear ports;
  - is instantiated only under `WB_SCOREBOARD_EN`.
- Arbitration, counters and the output register stay in the top module.

## Test plan
- **Single source:** reset, then `valid_in`=4'b0010, addr 6'd5, data 32'hDEADBEEF → `ready_out`=4'b0010 in the same cycle. Next cycle: `rd_wena_to_WB`=1, addr 5, data DEADBEEF. The following cycle: `rd_wena_to_WB`=0.
- **Fixed priority:** `valid_in`=4'b1011 held → grants 0, then 1, then 3 on successive cycles, with one write each cycle.
- **Starvation:** source 0 continuously re-asserts while source 2 is held valid → source 2 is granted on the 4th cycle (`wait_cnt`=3), then source 0 resumes.
- **x0 suppression:** source 0 with addr 0 → `ready_out[0]`=1, handshake completes, next-cycle `rd_wena_to_WB`=0. Addr 32 → `rd_wena_to_WB`=1.
- **Scoreboard** (`WB_SCOREBOARD_EN`):
  - `sb_set` with addr 7 → `busy[7]`=1 next cycle;
  - DIV writes 7 → `busy[7]`=0 when the write is presented;
  - `sb_set` addr 9 together with a write to 9 → `busy[9]` stays 1.
- **Async reset mid-transfer:** drop `reset` low while a grant is active → all outputs go to 0 immediately without a clock edge. After release, the held source is granted again.

Source files
------------

// File: rtl/CPU_pkg.sv
// Shared CPU definitions: write-back source indices, starvation default and
// the registered write-port record used by wb_arbiter.
package CPU_pkg;

    localparam int WB_SRC_EX         = 0;
    localparam int WB_SRC_MUL        = 1;
    localparam int WB_SRC_DIV        = 2;
    localparam int WB_SRC_FPU        = 3;
    localparam int WB_STARVE_LIM_DEF = 3;

    localparam int WB_ADDR_W   = 6;
    localparam int WB_DATA_W   = 32;
    localparam int WB_NUM_REGS = 64;

    typedef struct packed {
        logic                 wena;
        logic [WB_ADDR_W-1:0] addr;
        logic [WB_DATA_W-1:0] data;
    } wb_write_t;

endpackage

// File: rtl/wb_scoreboard.sv
// Pending-write mask for the register file: issue sets a bit, write-back
// clears it; a same-cycle issue to the same register keeps it pending.
module wb_scoreboard
    import CPU_pkg::*;
(
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   set_i,
    input  logic [WB_ADDR_W-1:0]   set_addr_i,
    input  logic                   clr_i,
    input  logic [WB_ADDR_W-1:0]   clr_addr_i,
    output logic [WB_NUM_REGS-1:0] busy_o
);

    logic [WB_NUM_REGS-1:0] busy_q;
    logic [WB_NUM_REGS-1:0] busy_d;

    // Set is applied after clear so a fresh issue supersedes the old write.
    always_comb begin
        busy_d = busy_q;
        if (clr_i) busy_d[clr_addr_i] = 1'b0;
        if (set_i) busy_d[set_addr_i] = 1'b1;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) busy_q <= '0;
        else         busy_q <= busy_d;
    end

    assign busy_o = busy_q;

endmodule

// File: rtl/wb_arbiter.sv
// Write-back arbiter: fixed-priority grant with starvation promotion feeding one
// registered register-file write port. Scoreboard built under WB_SCOREBOARD_EN.
module wb_arbiter
    import CPU_pkg::*;
#(
    parameter int N_SRC      = 4,
    parameter int STARVE_LIM = WB_STARVE_LIM_DEF
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [N_SRC-1:0]       valid_in,
    output logic [N_SRC-1:0]       ready_out,
    input  logic [6*N_SRC-1:0]     rd_addr_in,
    input  logic [32*N_SRC-1:0]    rd_data_in,
    output logic                   rd_wena_to_WB,
    output logic [5:0]             rd_addr_to_WB,
    output logic [31:0]            rd_data_to_WB,
    input  logic                   sb_set,
    input  logic [5:0]             sb_addr,
    output logic [63:0]            busy
);

    localparam int               CNT_W = $clog2(STARVE_LIM + 1);
    localparam logic [CNT_W-1:0] LIM   = CNT_W'(STARVE_LIM);

    logic [CNT_W-1:0] wait_q [N_SRC];
    logic [CNT_W-1:0] wait_d [N_SRC];
    logic [N_SRC-1:0] starved;
    logic [N_SRC-1:0] cand;
    logic [N_SRC-1:0] gnt;
    logic             xfer;
    logic [5:0]       g_addr;
    logic [31:0]      g_data;
    wb_write_t        wb_q;
    wb_write_t        wb_d;

    // Starved sources, when present, replace the plain valid set as candidates.
    always_comb begin
        starved = '0;
        for (int i = 0; i < N_SRC; i++) starved[i] = valid_in[i] && (wait_q[i] == LIM);
        cand = (|starved) ? starved : valid_in;
        gnt  = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (cand[i]) begin
                gnt    = '0;
                gnt[i] = 1'b1;
            end
        end
        if (!reset) gnt = '0;
    end

    assign ready_out = gnt;
    assign xfer      = |gnt;

    always_comb begin
        g_addr = '0;
        g_data = '0;
        for (int i = 0; i < N_SRC; i++) begin
            if (gnt[i]) begin
                g_addr = rd_addr_in[6*i +: 6];
                g_data = rd_data_in[32*i +: 32];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < N_SRC; i++) begin
            if (valid_in[i] && !gnt[i]) wait_d[i] = (wait_q[i] == LIM) ? LIM : wait_q[i] + CNT_W'(1);
            else                        wait_d[i] = '0;
        end
    end

    // x0 still completes its handshake; only the register write is dropped.
    always_comb begin
        wb_d.wena = xfer && (g_addr != 6'd0);
        wb_d.addr = g_addr;
        wb_d.data = g_data;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wb_q <= '0;
            for (int i = 0; i < N_SRC; i++) wait_q[i] <= '0;
        end else begin
            wb_q <= wb_d;
            for (int i = 0; i < N_SRC; i++) wait_q[i] <= wait_d[i];
        end
    end

    assign rd_wena_to_WB = wb_q.wena;
    assign rd_addr_to_WB = wb_q.addr;
    assign rd_data_to_WB = wb_q.data;

`ifdef WB_SCOREBOARD_EN
    wb_scoreboard u_scoreboard (
        .clk_i      (clk),
        .rst_ni     (reset),
        .set_i      (sb_set),
        .set_addr_i (sb_addr),
        .clr_i      (xfer),
        .clr_addr_i (g_addr),
        .busy_o     (busy)
    );
`else
    logic unused_sb;
    assign unused_sb = ^{sb_set, sb_addr};
    assign busy      = '0;
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: directed scenarios plus a randomized run against a
// cycle-level reference model of grant, write-back and scoreboard rules.
module tb_wb_arbiter;

    localparam int N   = 4;
    localparam int LIM = 3;
`ifdef WB_SCOREBOARD_EN
    localparam logic SB_EN = 1'b1;
`else
    localparam logic SB_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic [N-1:0]  valid_in;
    logic [N-1:0]  ready_out;
    logic [6*N-1:0]  rd_addr_in;
    logic [32*N-1:0] rd_data_in;
    logic          rd_wena_to_WB;
    logic [5:0]    rd_addr_to_WB;
    logic [31:0]   rd_data_to_WB;
    logic          sb_set;
    logic [5:0]    sb_addr;
    logic [63:0]   busy;

    int checks   = 0;
    int failures = 0;

    int          wait_m [N];
    logic        exp_wena;
    logic [5:0]  exp_addr;
    logic [31:0] exp_data;
    logic [63:0] exp_busy;
    logic [37:0] exp_q [$];

    wb_arbiter #(.N_SRC(N), .STARVE_LIM(LIM)) dut (
        .clk           (clk),
        .reset         (reset),
        .valid_in      (valid_in),
        .ready_out     (ready_out),
        .rd_addr_in    (rd_addr_in),
        .rd_data_in    (rd_data_in),
        .rd_wena_to_WB (rd_wena_to_WB),
        .rd_addr_to_WB (rd_addr_to_WB),
        .rd_data_to_WB (rd_data_to_WB),
        .sb_set        (sb_set),
        .sb_addr       (sb_addr),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic logic [N-1:0] model_grant(input logic [N-1:0] v);
        int pick;
        pick = -1;
        for (int i = 0; i < N; i++) if (pick < 0 && v[i] && wait_m[i] >= LIM) pick = i;
        for (int i = 0; i < N; i++) if (pick < 0 && v[i]) pick = i;
        if (pick < 0 || !reset) return '0;
        return N'(1) << pick;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < N; i++) wait_m[i] = 0;
        exp_wena = 1'b0;
        exp_addr = '0;
        exp_data = '0;
        exp_busy = '0;
        exp_q.delete();
    endfunction

    function automatic void model_commit();
        logic [N-1:0] g;
        g = model_grant(valid_in);
        for (int i = 0; i < N; i++)
            wait_m[i] = (valid_in[i] && !g[i]) ? ((wait_m[i] < LIM) ? wait_m[i] + 1 : LIM) : 0;
        exp_wena = 1'b0;
        exp_addr = '0;
        exp_data = '0;
        for (int i = 0; i < N; i++) begin
            if (g[i]) begin
                exp_addr = rd_addr_in[6*i +: 6];
                exp_data = rd_data_in[32*i +: 32];
                exp_wena = (exp_addr != 6'd0);
            end
        end
        if (exp_wena) exp_q.push_back({exp_addr, exp_data});
        if (SB_EN) begin
            if (g != '0) exp_busy[exp_addr] = 1'b0;
            if (sb_set)  exp_busy[sb_addr]  = 1'b1;
            exp_busy[0] = 1'b0;
        end
    endfunction

    // ---------------- driver tasks ----------------
    task automatic set_src(input int i, input logic v, input logic [5:0] a, input logic [31:0] d);
        valid_in[i]           = v;
        rd_addr_in[6*i +: 6]  = a;
        rd_data_in[32*i +: 32] = d;
    endtask

    task automatic cycle();
        @(posedge clk);
        if (!reset) model_reset();
        else        model_commit();
        #1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset = 1'b0; valid_in = '0; rd_addr_in = '0; rd_data_in = '0;
        sb_set = 1'b0; sb_addr = '0;
        model_reset();
        #12;
        checks++;
        if ({ready_out, rd_wena_to_WB, rd_addr_to_WB, rd_data_to_WB} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: ready=%b wena=%b addr=%0d data=%h, required all 0",
                     ready_out, rd_wena_to_WB, rd_addr_to_WB, rd_data_to_WB);
        end
        checks++;
        if (busy !== 64'h0) begin failures++; $display("FAIL reset_busy: got %h required 0", busy); end
        reset = 1'b1;
        cycle();
    endtask

    task automatic test_single_source();
        set_src(1, 1'b1, 6'd5, 32'hDEADBEEF);
        #1;
        checks++;
        if (ready_out !== 4'b0010) begin failures++; $display("FAIL single_ready: got %b required 0010", ready_out); end
        cycle();
        set_src(1, 1'b0, 6'd0, 32'h0);
        checks++;
        if ({rd_wena_to_WB, rd_addr_to_WB, rd_data_to_WB} !== {1'b1, 6'd5, 32'hDEADBEEF}) begin
            failures++;
            $display("FAIL single_write: got wena=%b addr=%0d data=%h required 1/5/deadbeef",
                     rd_wena_to_WB, rd_addr_to_WB, rd_data_to_WB);
        end
        cycle();
        checks++;
        if (rd_wena_to_WB !== 1'b0) begin failures++; $display("FAIL single_one_cycle: wena=%b required 0", rd_wena_to_WB); end
    endtask

    task automatic test_fixed_priority();
        int idx_tab [3] = '{0, 1, 3};
        set_src(0, 1'b1, 6'd10, $urandom);
        set_src(1, 1'b1, 6'd11, $urandom);
        set_src(3, 1'b1, 6'd13, $urandom);
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++;
            if (ready_out !== (4'b0001 << idx_tab[k])) begin
                failures++;
                $display("FAIL prio_grant[%0d]: got %b required %b", k, ready_out, 4'b0001 << idx_tab[k]);
            end
            cycle();
            set_src(idx_tab[k], 1'b0, 6'd0, 32'h0);
            checks++;
            if ({rd_wena_to_WB, rd_addr_to_WB} !== {1'b1, 6'(10 + idx_tab[k])}) begin
                failures++;
                $display("FAIL prio_write[%0d]: got wena=%b addr=%0d required 1/%0d",
                         k, rd_wena_to_WB, rd_addr_to_WB, 10 + idx_tab[k]);
            end
        end
        cycle();
    endtask

    task automatic test_starvation();
        int seq [5] = '{0, 0, 0, 2, 0};
        set_src(2, 1'b1, 6'd20, 32'h2020_2020);
        for (int k = 0; k < 5; k++) begin
            set_src(0, 1'b1, 6'd1, 32'h0100_0000 + 32'(k));
            #1;
            checks++;
            if (ready_out !== (4'b0001 << seq[k])) begin
                failures++;
                $display("FAIL starve_grant[%0d]: got %b required %b", k, ready_out, 4'b0001 << seq[k]);
            end
            cycle();
            if (seq[k] == 2) set_src(2, 1'b0, 6'd0, 32'h0);
            checks++;
            if (rd_addr_to_WB !== ((seq[k] == 2) ? 6'd20 : 6'd1)) begin
                failures++;
                $display("FAIL starve_write[%0d]: got addr=%0d required %0d",
                         k, rd_addr_to_WB, (seq[k] == 2) ? 20 : 1);
            end
        end
        set_src(0, 1'b0, 6'd0, 32'h0);
        cycle();
    endtask

    task automatic test_x0();
        logic [31:0] d;
        d = $urandom;
        set_src(0, 1'b1, 6'd0, d);
        #1;
        checks++;
        if (ready_out !== 4'b0001) begin failures++; $display("FAIL x0_ready: got %b required 0001", ready_out); end
        cycle();
        set_src(0, 1'b0, 6'd0, 32'h0);
        checks++;
        if (rd_wena_to_WB !== 1'b0) begin failures++; $display("FAIL x0_suppress: wena=%b required 0", rd_wena_to_WB); end
        set_src(0, 1'b1, 6'd32, d);
        #1;
        cycle();
        set_src(0, 1'b0, 6'd0, 32'h0);
        checks++;
        if ({rd_wena_to_WB, rd_addr_to_WB, rd_data_to_WB} !== {1'b1, 6'd32, d}) begin
            failures++;
            $display("FAIL f0_write: got wena=%b addr=%0d data=%h required 1/32/%h",
                     rd_wena_to_WB, rd_addr_to_WB, rd_data_to_WB, d);
        end
    endtask

    task automatic test_scoreboard();
        sb_set = 1'b1; sb_addr = 6'd7;
        cycle();
        sb_set = 1'b0;
        checks++;
        if (busy[7] !== SB_EN) begin failures++; $display("FAIL sb_set7: busy[7]=%b required %b", busy[7], SB_EN); end
        set_src(2, 1'b1, 6'd7, 32'h0000_0707);
        #1;
        cycle();
        set_src(2, 1'b0, 6'd0, 32'h0);
        checks++;
        if ({rd_wena_to_WB, busy[7]} !== 2'b10) begin
            failures++;
            $display("FAIL sb_clear7: wena=%b busy[7]=%b required 1/0", rd_wena_to_WB, busy[7]);
        end
        sb_set = 1'b1; sb_addr = 6'd9;
        cycle();
        set_src(1, 1'b1, 6'd9, 32'h0000_0909);
        #1;
        cycle();
        set_src(1, 1'b0, 6'd0, 32'h0);
        sb_set = 1'b0;
        checks++;
        if (busy[9] !== SB_EN) begin failures++; $display("FAIL sb_set_wins9: busy[9]=%b required %b", busy[9], SB_EN); end
        checks++;
        if (busy !== exp_busy) begin failures++; $display("FAIL sb_mask: got %h required %h", busy, exp_busy); end
    endtask

    task automatic test_random();
        logic [N-1:0] exp_g;
        logic [37:0]  w;
        exp_q.delete();
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++)
                if (!valid_in[i] && $urandom_range(0, 2) != 0)
                    set_src(i, 1'b1, 6'($urandom_range(0, 63)), $urandom);
            sb_set  = ($urandom_range(0, 3) == 0);
            sb_addr = 6'($urandom_range(0, 63));
            #1;
            exp_g = model_grant(valid_in);
            checks++;
            if (ready_out !== exp_g) begin failures++; $display("FAIL rand_grant[%0d]: got %b required %b", c, ready_out, exp_g); end
            cycle();
            for (int i = 0; i < N; i++) if (exp_g[i]) valid_in[i] = 1'b0;
            checks++;
            if ({rd_wena_to_WB, rd_addr_to_WB, rd_data_to_WB} !== {exp_wena, exp_addr, exp_data}) begin
                failures++;
                $display("FAIL rand_write[%0d]: got %b/%0d/%h required %b/%0d/%h", c, rd_wena_to_WB,
                         rd_addr_to_WB, rd_data_to_WB, exp_wena, exp_addr, exp_data);
            end
            checks++;
            if (busy !== exp_busy) begin failures++; $display("FAIL rand_busy[%0d]: got %h required %h", c, busy, exp_busy); end
            if (rd_wena_to_WB === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL rand_unexpected_write[%0d]: addr=%0d with no pending write", c, rd_addr_to_WB);
                end else begin
                    w = exp_q.pop_front();
                    if ({rd_addr_to_WB, rd_data_to_WB} !== w) begin
                        failures++;
                        $display("FAIL rand_order[%0d]: got %0d/%h required %0d/%h", c,
                                 rd_addr_to_WB, rd_data_to_WB, w[37:32], w[31:0]);
                    end
                end
            end
        end
        sb_set = 1'b0;
        valid_in = '0;
        cycle();
        checks++;
        if (exp_q.size() != 0) begin failures++; $display("FAIL rand_drain: %0d writes never presented", exp_q.size()); end
    endtask

    task automatic test_async_reset();
        set_src(0, 1'b1, 6'd3, 32'h1111_2222);
        #1;
        cycle();
        set_src(0, 1'b0, 6'd0, 32'h0);
        set_src(2, 1'b1, 6'd12, 32'hABCD_0012);
        #1;
        checks++;
        if ({ready_out, rd_wena_to_WB} !== {4'b0100, 1'b1}) begin
            failures++;
            $display("FAIL arst_pre: ready=%b wena=%b required 0100/1", ready_out, rd_wena_to_WB);
        end
        #2 reset = 1'b0;
        #1;
        checks++;
        if ({ready_out, rd_wena_to_WB, rd_addr_to_WB, rd_data_to_WB, busy} !== '0) begin
            failures++;
            $display("FAIL arst_async: ready=%b wena=%b addr=%0d data=%h busy=%h required all 0",
                     ready_out, rd_wena_to_WB, rd_addr_to_WB, rd_data_to_WB, busy);
        end
        model_reset();
        cycle();
        reset = 1'b1;
        #1;
        checks++;
        if (ready_out !== 4'b0100) begin failures++; $display("FAIL arst_regrant: got %b required 0100", ready_out); end
        cycle();
        set_src(2, 1'b0, 6'd0, 32'h0);
        checks++;
        if ({rd_wena_to_WB, rd_addr_to_WB, rd_data_to_WB} !== {1'b1, 6'd12, 32'hABCD_0012}) begin
            failures++;
            $display("FAIL arst_write: got %b/%0d/%h required 1/12/abcd0012",
                     rd_wena_to_WB, rd_addr_to_WB, rd_data_to_WB);
        end
        cycle();
    endtask

    initial begin
        test_reset();
        test_single_source();
        test_fixed_priority();
        test_starvation();
        test_x0();
        test_scoreboard();
        test_random();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

endmodule
